// File: rtl/subtractor32_pkg.sv
// -----------------------------------------------------------------------------
// subtractor32_pkg
// Shared definitions for the digit-serial 32-bit subtractor:
//   WIDTH       - operand/result width (32)
//   state_e     - sequencer states (IDLE, RUN, DONE)
//   num_digits  - number of RUN cycles for a given digit width
// -----------------------------------------------------------------------------
package subtractor32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int digit_w);
    return WIDTH / digit_w;
  endfunction

endpackage

// File: rtl/subtractor32_serial_digit.sv
// -----------------------------------------------------------------------------
// subtractor_digit
// Purely combinational W-bit subtract slice: diff = a - b - borrow_in.
// Ports:
//   a_i      [W-1:0]  minuend digit
//   b_i      [W-1:0]  subtrahend digit
//   borrow_i          borrow into the LSB of the digit
//   diff_o   [W-1:0]  difference digit
//   borrow_o          borrow out of the MSB of the digit
// -----------------------------------------------------------------------------
module subtractor_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         borrow_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] ext_diff;

  // One extra bit on the left catches the borrow as a wrap of the top bit.
  always_comb begin
    ext_diff = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
  end

  assign diff_o   = ext_diff[W-1:0];
  assign borrow_o = ext_diff[W];

endmodule

// File: rtl/subtractor32_serial.sv
// -----------------------------------------------------------------------------
// subtractor32_serial
// Digit-serial 32-bit subtractor: diff = a - b - borrow_in, computed DIGIT_W
// bits per clock starting at the least significant digit. The result is held
// in DONE until the consumer accepts it with ready_i.
//
// Build option: define SUBTRACTOR32_SAT_EN to saturate diff_o on signed
// overflow (0x7FFFFFFF for non-negative minuend, 0x80000000 otherwise).
// Without it diff_o is the raw wrapped result. borrow_o and overflow_o are
// identical in both builds.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   a_i, b_i    32-bit minuend / subtrahend
//   borrow_i    borrow-in at bit 0
//   valid_i     operands valid (taken only in IDLE)
//   ready_o     block can accept operands (IDLE)
//   diff_o      32-bit result
//   borrow_o    final borrow-out (unsigned a < b + borrow_i)
//   overflow_o  signed two's-complement overflow
//   zero_o      diff_o equals zero
//   valid_o     result valid (DONE)
//   ready_i     consumer accepts result
// -----------------------------------------------------------------------------
module subtractor32_serial
  import subtractor32_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic              borrow_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [WIDTH-1:0]  diff_o,
  output logic              borrow_o,
  output logic              overflow_o,
  output logic              zero_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int DIGITS = num_digits(DIGIT_W);
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               valid_q, valid_d;

  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] d_dig;
  logic               bo_dig;
  logic [WIDTH-1:0]   raw_diff;
  logic [WIDTH-1:0]   final_diff;
  logic               ovf_calc;
  logic               last_digit;

  // Select digit k of the captured operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  subtractor_digit #(
    .W (DIGIT_W)
  ) u_digit (
    .a_i      (a_dig),
    .b_i      (b_dig),
    .borrow_i (borrow_q),
    .diff_o   (d_dig),
    .borrow_o (bo_dig)
  );

  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // Diff register with digit k replaced by this cycle's slice result; on the
  // last digit this is the complete raw wrapped difference.
  always_comb begin
    raw_diff = diff_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        raw_diff[i*DIGIT_W +: DIGIT_W] = d_dig;
      end
    end
  end

  // Overflow is judged on the raw result, never on the saturated one.
  assign ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (raw_diff[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    final_diff = raw_diff;
`ifdef SUBTRACTOR32_SAT_EN
    if (ovf_calc) begin
      final_diff = a_q[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    valid_d      = valid_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = borrow_i;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        diff_d   = raw_diff;
        borrow_d = bo_dig;
        if (last_digit) begin
          diff_d       = final_diff;
          borrow_out_d = bo_dig;
          ovf_d        = ovf_calc;
          zero_d       = (final_diff == '0);
          valid_d      = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
      zero_q       <= zero_d;
      valid_q      <= valid_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign diff_o     = diff_q;
  assign borrow_o   = borrow_out_q;
  assign overflow_o = ovf_q;
  assign zero_o     = zero_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_subtractor32_serial.sv
// -----------------------------------------------------------------------------
// tb_subtractor32_serial
// Directed and random operands against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_subtractor32_serial;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 32 / DIGIT_W;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        borrow_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] diff_o;
  logic        borrow_o;
  logic        overflow_o;
  logic        zero_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  subtractor32_serial #(.DIGIT_W(DIGIT_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .borrow_i   (borrow_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .diff_o     (diff_o),
    .borrow_o   (borrow_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operands.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                       output logic [31:0] d, output logic bo, output logic ovf,
                       output logic zr);
    longint ua, ub, ur, sa, sb, sr;
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ur  = ua - ub - longint'(bi);
    d   = ur[31:0];
    bo  = (ua < ub + longint'(bi));
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sr  = sa - sb - longint'(bi);
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef SUBTRACTOR32_SAT_EN
    if (ovf) d = (sr < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    zr  = (d == 32'h0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("ready_before_issue", {31'b0, ready_o}, 32'd1);
    a_i      = a;
    b_i      = b;
    borrow_i = bi;
    valid_i  = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    borrow_i = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic check_outputs(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [31:0] ed;
    logic eb, eo, ez;
    model(a, b, bi, ed, eb, eo, ez);
    chk("diff", diff_o, ed);
    chk("borrow", {31'b0, borrow_o}, {31'b0, eb});
    chk("overflow", {31'b0, overflow_o}, {31'b0, eo});
    chk("zero", {31'b0, zero_o}, {31'b0, ez});
    chk("valid_done", {31'b0, valid_o}, 32'd1);
    chk("ready_in_done", {31'b0, ready_o}, 32'd0);
  endtask

  task automatic accept_result();
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    chk("ready_after_ack", {31'b0, ready_o}, 32'd1);
    chk("valid_after_ack", {31'b0, valid_o}, 32'd0);
  endtask

  task automatic full_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int lat;
    issue(a, b, bi);
    wait_result(lat);
    chk("latency", lat, DIGITS);
    check_outputs(a, b, bi);
    accept_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ha, hb, hold_diff;
    logic        hbi;
    int          lat;

    // Reset state
    rst_i = 1'b1;
    #12;
    chk("rst_diff", diff_o, 32'h0);
    chk("rst_borrow", {31'b0, borrow_o}, 32'd0);
    chk("rst_overflow", {31'b0, overflow_o}, 32'd0);
    chk("rst_zero", {31'b0, zero_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed corners
    full_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    full_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    full_op(32'h0000_0000, 32'h0000_0000, 1'b1);
    full_op(32'h8000_0000, 32'h0000_0001, 1'b0);
    full_op(32'h8000_0000, 32'h0000_0000, 1'b1);
    full_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    full_op(32'h1234_5678, 32'h1234_5678, 1'b0);
    full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    full_op(32'h0000_000F, 32'h0000_000F, 1'b1);

    // Hold in DONE with valid_i toggling; nothing must be captured
    ha = 32'hDEAD_BEEF; hb = 32'h1357_9BDF; hbi = 1'b1;
    issue(ha, hb, hbi);
    wait_result(lat);
    chk("hold_latency", lat, DIGITS);
    hold_diff = diff_o;
    for (int i = 0; i < 5; i++) begin
      valid_i = ~valid_i;
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk_i);
      #1;
      check_outputs(ha, hb, hbi);
      chk("hold_stable", diff_o, hold_diff);
    end
    valid_i = 1'b0;
    accept_result();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      chk("no_queued_capture", {31'b0, ready_o}, 32'd1);
    end

    // Reset during the 4th RUN cycle
    issue(32'hCAFE_F00D, 32'h0BAD_F00D, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, valid_o}, 32'd0);
    chk("midrst_diff", diff_o, 32'h0);
    chk("midrst_borrow", {31'b0, borrow_o}, 32'd0);
    chk("midrst_overflow", {31'b0, overflow_o}, 32'd0);
    chk("midrst_zero", {31'b0, zero_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("postrst_ready", {31'b0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    chk("postrst_no_stale", {31'b0, valid_o}, 32'd0);
    full_op(32'h0000_1000, 32'h0000_0FFF, 1'b0);

    // Random operands
    for (int i = 0; i < 30; i++) begin
      full_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subtractor32_serial.md
SUBTRACTOR32_SERIAL -- requirements
Module: subtractor32_serial

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, digit width processed per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port a_i  input  32  minuend.
REQ-005 SHALL have port b_i  input  32  subtrahend.
REQ-006 SHALL have port borrow_i  input  1  borrow-in, subtracted at bit 0.
REQ-007 SHALL have port valid_i  input  1  operands valid.
REQ-008 SHALL have port ready_o  output  1  block can accept operands.
REQ-009 SHALL have port diff_o  output  32  result, a_i - b_i - borrow_i.
REQ-010 SHALL have port borrow_o  output  1  final borrow-out (unsigned a < b + borrow_i).
REQ-011 SHALL have port overflow_o  output  1  signed two's-complement overflow.
REQ-012 SHALL have port zero_o  output  1  delivered diff_o equals 0.
REQ-013 SHALL have port valid_o  output  1  result valid.
REQ-014 SHALL have port ready_i  input  1  consumer accepts result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: ready_o=1; on valid_i=1, SHALL capture a_i, b_i, borrow_i, clear digit counter and diff register, and go to RUN.
REQ-017 RUN: each cycle SHALL subtract digit k of b and the running borrow from digit k of a, write digit k of the diff register, latch the borrow, and increment k, starting at the LSB digit.
REQ-018 SHALL leave RUN for DONE after exactly 32/DIGIT_W RUN cycles; with DIGIT_W=4, valid_o SHALL rise 8 cycles after the accepting edge.
REQ-019 DONE: valid_o=1; diff_o, borrow_o, overflow_o and zero_o SHALL stay stable until the cycle with ready_i=1, then the FSM SHALL return to IDLE.
REQ-020 ready_o SHALL be 0 in RUN and DONE; valid_i asserted there SHALL be ignored, with no queuing.
REQ-021 overflow_o SHALL be (a[31] != b[31]) AND (raw diff[31] != a[31]), computed on the raw wrapped result.
REQ-022 zero_o SHALL be computed on the value actually driven on diff_o.
REQ-023 Outside DONE, the value of the result outputs is don't-care to the consumer; valid_o SHALL be 0.
REQ-024 Arithmetic SHALL be modulo 2^32 with no sign extension.

Reset
REQ-025 rst_i=1 SHALL immediately force IDLE, with diff_o, borrow_o, overflow_o, zero_o and valid_o all at 0 and the counter at 0.
REQ-026 Reset during RUN or DONE SHALL abandon the operation; after release, ready_o=1 on the first cycle and no stale result SHALL appear.

Configuration
REQ-027 Macro SUBTRACTOR32_SAT_EN defined: on overflow_o=1, diff_o SHALL saturate to 32'h7FFFFFFF if a[31]=0, else to 32'h80000000.
REQ-028 Macro SUBTRACTOR32_SAT_EN undefined: diff_o SHALL be the raw wrapped result; no saturation logic SHALL be synthesized.
REQ-029 Under both settings, overflow_o and borrow_o SHALL be identical.

Structure
REQ-030 Package subtractor32_pkg SHALL hold the state enum typedef, the constant WIDTH=32, and the function computing DIGITS=WIDTH/DIGIT_W.
REQ-031 SHALL instantiate one sub-module, subtractor_digit (parameter W; inputs a, b, borrow-in; outputs diff, borrow-out), purely combinational.

Verification
REQ-032 a=0x00000005, b=0x00000003, borrow_i=0 -> diff 0x00000002, borrow_o 0, overflow_o 0, zero_o 0; valid_o 8 cycles after accept.
REQ-033 a=0x00000000, b=0x00000001 -> diff 0xFFFFFFFF, borrow_o 1, overflow_o 0; with borrow_i=1 and b=0 -> same result.
REQ-034 a=0x80000000, b=0x00000001 -> overflow_o 1; diff 0x7FFFFFFF without the macro, 0x80000000 with SUBTRACTOR32_SAT_EN.
REQ-035 a=b=0x12345678 -> diff 0, zero_o 1, borrow_o 0.
REQ-036 ready_i held 0 for 5 cycles in DONE while valid_i toggles -> outputs stable, ready_o 0, no new capture; ready_i=1 -> IDLE the next cycle.
REQ-037 rst_i pulsed in the 4th RUN cycle -> valid_o 0 and outputs 0 at once; after release, a fresh operand pair completes correctly in 8 cycles.
